// File: rtl/alt_vipcti131_reader_pkg.sv
// Shared definitions for the CVI FIFO stream reader: state encoding and
// the positions of the packet flags inside each FIFO word.
package alt_vipcti131_reader_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_RUN      = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  // sop flag sits just above the eop flag, both above the pixel payload
  function automatic int sop_bit(input int pixel_width);
    return pixel_width + 1;
  endfunction

  function automatic int eop_bit(input int pixel_width);
    return pixel_width;
  endfunction

endpackage

// File: rtl/alt_vipcti131_two_entry_buffer.sv
// Two-deep register FIFO feeding the Avalon-ST output. Entry 0 is the head.
// Caller guarantees no push when full and no pop when empty.
module alt_vipcti131_two_entry_buffer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;

  assign head = entry0;

  // Entry shifting and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= din;
          else               entry1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new word lands behind whatever stays
          if (count == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alt_vipcti131_fifo_stream_reader.sv
// Reads the CVI input FIFO (non-showahead, 1-cycle latency) and re-emits
// its words as Avalon-ST video. Aligns to a sop on start, stops only after
// an eop, and keeps packet / dropped-word statistics.
module alt_vipcti131_fifo_stream_reader
  import alt_vipcti131_reader_pkg::*;
#(
  parameter int PIXEL_WIDTH = 18,
  parameter int WORD_WIDTH  = PIXEL_WIDTH + 2,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic                   clear_stats,
  output logic                   rdreq,
  input  logic                   rdempty,
  input  logic [WORD_WIDTH-1:0]  q,
  output logic [PIXEL_WIDTH-1:0] dout_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_startofpacket,
  output logic                   dout_endofpacket,
  output logic                   status_running,
  output logic [STAT_WIDTH-1:0]  packets_out,
  output logic [STAT_WIDTH-1:0]  dropped_words
);

  localparam int SOP_BIT = sop_bit(PIXEL_WIDTH);
  localparam int EOP_BIT = eop_bit(PIXEL_WIDTH);

  state_t                state;
  state_t                state_nxt;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  read_allowed;
  logic [1:0]            count;
  logic [2:0]            space;
  logic [WORD_WIDTH-1:0] head;
  logic                  ret_sop;
  logic                  ret_eop;

  assign ret_sop = q[SOP_BIT];
  assign ret_eop = q[EOP_BIT];

  alt_vipcti131_two_entry_buffer #(.WIDTH(WORD_WIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (q),
    .head  (head),
    .count (count)
  );

  assign dout_valid         = (count != 2'd0);
  assign pop                = dout_valid && dout_ready;
  assign dout_data          = dout_valid ? head[PIXEL_WIDTH-1:0] : '0;
  assign dout_startofpacket = dout_valid && head[SOP_BIT];
  assign dout_endofpacket   = dout_valid && head[EOP_BIT];
  assign status_running     = (state != ST_DISABLED);

  // Free slots once this cycle's pop and the word already in flight are
  // accounted for; never negative because an in-flight word always holds
  // a reserved slot.
  assign space = 3'd2 - {1'b0, count} + {2'b0, pop} - {2'b0, inflight};

  // Which states may issue a FIFO read; DRAIN reads one word at a time so
  // it never fetches past the eop.
  always_comb begin
    read_allowed = 1'b0;
    case (state)
      ST_SYNC:  read_allowed = go;
      ST_RUN:   read_allowed = go;
      ST_DRAIN: read_allowed = !inflight;
      default:  read_allowed = 1'b0;
    endcase
  end

  assign rdreq = !rdempty && (space != 3'd0) && read_allowed;

  // Marks the cycle in which q carries the word requested last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= rdreq;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_DISABLED;
    else        state <= state_nxt;
  end

  // Next state plus push/drop decision for the returning word
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_DISABLED: begin
        drop = inflight;
        if (go) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (inflight && ret_sop) begin
          push      = 1'b1;
          state_nxt = (ret_eop && !go) ? ST_DISABLED : ST_RUN;
        end else begin
          drop = inflight;
          if (!go) state_nxt = ST_DISABLED;
        end
      end
      ST_RUN: begin
        push = inflight;
        if (!go) state_nxt = (inflight && ret_eop) ? ST_DISABLED : ST_DRAIN;
      end
      ST_DRAIN: begin
        push = inflight;
        if (inflight && ret_eop) state_nxt = ST_DISABLED;
      end
      default: state_nxt = ST_DISABLED;
    endcase
  end

  // Packet counter: wraps; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          packets_out <= '0;
    else if (clear_stats)                packets_out <= '0;
    else if (pop && head[EOP_BIT])       packets_out <= packets_out + 1'b1;
  end

  // Dropped-word counter: saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            dropped_words <= '0;
    else if (clear_stats)                  dropped_words <= '0;
    else if (drop && (dropped_words != '1)) dropped_words <= dropped_words + 1'b1;
  end

endmodule
